sram_sp_req_ctrl: RTL

//  Initiator-side controller for a single-port synchronous SRAM macro: active-low CEB/WEB, registered Q one cycle after a read.

---
 rtl/sram_sp_req_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/sram_sp_req_ctrl.sv
// Request-stream controller for a single-port SRAM macro with active-low CEB/WEB.
// Zero-fills the array after reset and returns read data through a small response FIFO.
module sram_sp_req_ctrl #(
   parameter int DATA_W        = 16,
   parameter int DEPTH         = 256,
   parameter int ADDR_W        = 8,
   parameter int RESP_DEPTH    = 3,
   parameter int INIT_ON_RESET = 1
) (
   input  logic              i_clock,
   input  logic              i_reset,
   output logic              o_init_done,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_write,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [DATA_W-1:0] i_req_wdata,
   output logic              o_resp_valid,
   input  logic              i_resp_ready,
   output logic [DATA_W-1:0] o_resp_rdata,
   output logic              o_sram_ceb,
   output logic              o_sram_web,
   output logic [ADDR_W-1:0] o_sram_a,
   output logic [DATA_W-1:0] o_sram_d,
   input  logic [DATA_W-1:0] i_sram_q
);

   localparam int CW = $clog2(RESP_DEPTH + 1);
   localparam int PW = $clog2(RESP_DEPTH);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_cnt;
   logic              r_inflight;
   logic [DATA_W-1:0] r_q [RESP_DEPTH];
   logic [PW-1:0]     r_wp;
   logic [PW-1:0]     r_rp;
   logic [CW-1:0]     r_count;

   logic w_run;
   logic w_room;
   logic w_fire;
   logic w_rd_fire;
   logic w_enq;
   logic w_deq;

   function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
      return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Room counts the read already in flight so the FIFO can never overflow.
   assign w_room = ({1'b0, r_count} + {{CW{1'b0}}, r_inflight})
                   < (CW+1)'(RESP_DEPTH);
   assign w_run        = (r_state == ST_RUN) & ~i_reset;
   assign o_req_ready  = w_run & (i_req_write | w_room);
   assign w_fire       = i_req_valid & o_req_ready;
   assign w_rd_fire    = w_fire & ~i_req_write;
   assign w_enq        = r_inflight;
   assign o_resp_valid = (r_count != '0);
   assign w_deq        = o_resp_valid & i_resp_ready;
   assign o_resp_rdata = r_q[r_rp];
   assign o_init_done  = (r_state == ST_RUN);

   always_comb begin
      o_sram_ceb = 1'b1;
      o_sram_web = 1'b1;
      o_sram_a   = '0;
      o_sram_d   = '0;
      if (!i_reset) begin
         if (r_state == ST_INIT) begin
            if (INIT_ON_RESET != 0) begin
               o_sram_ceb = 1'b0;
               o_sram_web = 1'b0;
               o_sram_a   = r_cnt;
            end
         end else if (w_fire) begin
            o_sram_ceb = 1'b0;
            o_sram_web = ~i_req_write;
            o_sram_a   = i_req_addr;
            o_sram_d   = i_req_write ? i_req_wdata : '0;
         end
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state    <= ST_INIT;
         r_cnt      <= '0;
         r_inflight <= 1'b0;
         r_wp       <= '0;
         r_rp       <= '0;
         r_count    <= '0;
         for (int i = 0; i < RESP_DEPTH; i++) r_q[i] <= '0;
      end else begin
         unique case (r_state)
            ST_INIT: begin
               if (INIT_ON_RESET == 0 || r_cnt == ADDR_W'(DEPTH - 1))
                  r_state <= ST_RUN;
               else
                  r_cnt <= r_cnt + 1'b1;
            end
            ST_RUN: r_state <= ST_RUN;
         endcase
         // Q is only meaningful in the cycle right after a read fire.
         r_inflight <= w_rd_fire;
         if (w_enq) begin
            r_q[r_wp] <= i_sram_q;
            r_wp      <= f_inc(r_wp);
         end
         if (w_deq) r_rp <= f_inc(r_rp);
         unique case ({w_enq, w_deq})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         assert (r_count <= CW'(RESP_DEPTH));
      end
   end

endmodule
